// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute stage. Drives register-file read addresses,
// resolves each source operand from the EX/MEM/WB bypass network or the
// register file, stalls on load-use hazards, and registers the result into
// the ID/EX pipeline register behind a valid/ready handshake.
module operand_fetch #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        rf_rs1,
    output logic [4:0]        rf_rs2,
    input  logic [XLEN-1:0]   rf_r1,
    input  logic [XLEN-1:0]   rf_r2,
    input  logic              ex_fwd_valid,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_rd,
    input  logic [XLEN-1:0]   ex_data,
    input  logic              mem_fwd_valid,
    input  logic [4:0]        mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_wen,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [15:0]       stall_cnt
);

    // Bypass priority: youngest producer wins. A load in EX has no data yet,
    // so it never forwards (the hazard logic holds the consumer instead).
    // WB must be bypassed because the register file writes at the same edge
    // and a same-cycle read still returns the old value.
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_v,
        input logic            ex_ld,
        input logic [4:0]      ex_r,
        input logic [XLEN-1:0] ex_d,
        input logic            mem_v,
        input logic [4:0]      mem_r,
        input logic [XLEN-1:0] mem_d,
        input logic            wb_v,
        input logic [4:0]      wb_r,
        input logic [XLEN-1:0] wb_d
    );
        logic [XLEN-1:0] val;
        if (idx == 5'd0)
            val = '0;
        else if (ex_v && !ex_ld && (ex_r == idx))
            val = ex_d;
        else if (mem_v && (mem_r == idx))
            val = mem_d;
        else if (wb_v && (wb_r == idx))
            val = wb_d;
        else
            val = rf_val;
        return val;
    endfunction

    // Saturating increment for the stall counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic              vld_p1;
    logic [XLEN-1:0]   op1_p1;
    logic [XLEN-1:0]   op2_p1;
    logic [XLEN-1:0]   imm_p1;
    logic [XLEN-1:0]   pc_p1;
    logic [4:0]        rd_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [15:0]       stall_q;

    logic [XLEN-1:0]   op1_p0;
    logic [XLEN-1:0]   op2_p0;
    logic              hazard;
    logic              slot_free;
    logic              accept;

    assign rf_rs1 = in_rs1;
    assign rf_rs2 = in_rs2;

    // Stage p0: operand selection, hazard detection and handshake.
    always_comb begin
        op1_p0 = pick_operand(in_rs1, rf_r1, ex_fwd_valid, ex_is_load, ex_rd, ex_data,
                              mem_fwd_valid, mem_rd, mem_data, wb_wen, wb_rd, wb_data);
        op2_p0 = pick_operand(in_rs2, rf_r2, ex_fwd_valid, ex_is_load, ex_rd, ex_data,
                              mem_fwd_valid, mem_rd, mem_data, wb_wen, wb_rd, wb_data);
        hazard = in_valid && ex_fwd_valid && ex_is_load && (ex_rd != 5'd0) &&
                 ((in_use_rs1 && (in_rs1 == ex_rd)) || (in_use_rs2 && (in_rs2 == ex_rd)));
        slot_free = !vld_p1 || out_ready;
        in_ready  = slot_free && !hazard && !flush;
        accept    = in_valid && in_ready;
    end

    // Stage p1: ID/EX register; holds while the consumer back-pressures.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            op1_p1  <= '0;
            op2_p1  <= '0;
            imm_p1  <= '0;
            pc_p1   <= '0;
            rd_p1   <= '0;
            ctrl_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            op1_p1  <= op1_p0;
            op2_p1  <= op2_p0;
            imm_p1  <= in_imm;
            pc_p1   <= in_pc;
            rd_p1   <= in_rd;
            ctrl_p1 <= in_ctrl;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Count cycles lost to load-use stalls (only when the slot could otherwise advance).
    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= 16'd0;
        else if (hazard && !flush && slot_free)
            stall_q <= sat_inc(stall_q);
    end

    assign out_valid = vld_p1;
    assign out_op1   = op1_p1;
    assign out_op2   = op2_p1;
    assign out_imm   = imm_p1;
    assign out_pc    = pc_p1;
    assign out_rd    = rd_p1;
    assign out_ctrl  = ctrl_p1;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use_rs1, in_use_rs2;
    logic [31:0] in_imm, in_pc;
    logic [15:0] in_ctrl;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_r1, rf_r2;
    logic        ex_fwd_valid, ex_is_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        mem_fwd_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_op1, out_op2, out_imm, out_pc;
    logic [4:0]  out_rd;
    logic [15:0] out_ctrl;
    logic [15:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    operand_fetch #(.XLEN(32), .CTRL_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_imm(in_imm), .in_pc(in_pc), .in_ctrl(in_ctrl),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_r1(rf_r1), .rf_r2(rf_r2),
        .ex_fwd_valid(ex_fwd_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_fwd_valid(mem_fwd_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_pc(out_pc),
        .out_rd(out_rd), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [31:0] rf1, rf2;
        logic        exv, exl;
        logic [4:0]  exrd;
        logic [31:0] exd;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        e_rdy;
        logic [31:0] e_op1, e_op2;
    } vec_t;

    typedef struct {
        logic [31:0] op1, op2, imm, pc;
        logic [4:0]  rd;
        logic [15:0] ctrl;
    } rec_t;

    vec_t vecs[10];
    rec_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_use_rs1 = 0; in_use_rs2 = 0;
        in_imm = 0; in_pc = 0; in_ctrl = 0; rf_r1 = 0; rf_r2 = 0;
        ex_fwd_valid = 0; ex_is_load = 0; ex_rd = 0; ex_data = 0;
        mem_fwd_valid = 0; mem_rd = 0; mem_data = 0;
        wb_wen = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // First matching producer in youngest-first order; x0 is always zero.
    function automatic logic [31:0] ref_op(input logic [4:0] idx, input logic [31:0] rfv);
        logic        sv[3];
        logic [4:0]  sr[3];
        logic [31:0] sd[3];
        if (idx == 0) return 32'd0;
        sv[0] = ex_fwd_valid && !ex_is_load; sr[0] = ex_rd;  sd[0] = ex_data;
        sv[1] = mem_fwd_valid;               sr[1] = mem_rd; sd[1] = mem_data;
        sv[2] = wb_wen;                      sr[2] = wb_rd;  sd[2] = wb_data;
        for (int k = 0; k < 3; k++)
            if (sv[k] && sr[k] == idx) return sd[k];
        return rfv;
    endfunction

    initial begin
        int exp_stall;
        rst = 1;
        clr_in();
        tick();
        tick();
        rst = 0;

        // Reset state and idle
        chk("rst_valid", out_valid, 0);
        chk("rst_op1", out_op1, 0);
        chk("rst_op2", out_op2, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("idle_ready", in_ready, 1);

        // First accept
        in_valid = 1; in_rs1 = 3; in_rs2 = 4; in_use_rs1 = 1; in_use_rs2 = 1;
        rf_r1 = 32'h11; rf_r2 = 32'h22; in_rd = 5'd9; in_ctrl = 16'hBEEF; in_imm = 32'h77;
        #1;
        chk("first_ready", in_ready, 1);
        chk("rf_rs1", rf_rs1, 3);
        chk("rf_rs2", rf_rs2, 4);
        tick();
        in_valid = 0;
        chk("first_valid", out_valid, 1);
        chk("first_op1", out_op1, 32'h11);
        chk("first_op2", out_op2, 32'h22);
        chk("first_rd", out_rd, 9);
        chk("first_ctrl", out_ctrl, 16'hBEEF);
        chk("first_imm", out_imm, 32'h77);

        // Directed operand-select vectors
        vecs[0] = '{5'd5, 5'd9, 1, 1, 32'hD, 32'h99, 1, 0, 5'd5, 32'hA, 1, 5'd5, 32'hB, 1, 5'd5, 32'hC, 1, 32'hA, 32'h99};
        vecs[1] = '{5'd5, 5'd9, 1, 1, 32'hD, 32'h99, 0, 0, 5'd5, 32'hA, 1, 5'd5, 32'hB, 1, 5'd5, 32'hC, 1, 32'hB, 32'h99};
        vecs[2] = '{5'd5, 5'd9, 1, 1, 32'hD, 32'h99, 0, 0, 5'd5, 32'hA, 0, 5'd5, 32'hB, 1, 5'd5, 32'hC, 1, 32'hC, 32'h99};
        vecs[3] = '{5'd5, 5'd9, 1, 1, 32'hD, 32'h99, 0, 0, 5'd5, 32'hA, 0, 5'd5, 32'hB, 0, 5'd5, 32'hC, 1, 32'hD, 32'h99};
        vecs[4] = '{5'd0, 5'd9, 1, 1, 32'hD, 32'h99, 1, 0, 5'd0, 32'hA, 1, 5'd0, 32'hB, 1, 5'd0, 32'hC, 1, 32'h0, 32'h99};
        vecs[5] = '{5'd1, 5'd6, 0, 1, 32'h1, 32'h99, 1, 1, 5'd6, 32'hE, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0};
        vecs[6] = '{5'd1, 5'd6, 0, 0, 32'h1, 32'h99, 1, 1, 5'd6, 32'hE, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 1, 32'h1, 32'h66};
        vecs[7] = '{5'd8, 5'd8, 1, 1, 32'h11, 32'h22, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd8, 32'h88, 1, 32'h88, 32'h88};
        vecs[8] = '{5'd5, 5'd9, 1, 1, 32'hD, 32'h99, 1, 0, 5'd4, 32'hA, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 32'hD, 32'h99};
        vecs[9] = '{5'd0, 5'd9, 1, 1, 32'h5, 32'h99, 1, 1, 5'd0, 32'hA, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 32'h0, 32'h99};
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; out_ready = 1;
            in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2;
            in_use_rs1 = vecs[i].u1; in_use_rs2 = vecs[i].u2;
            rf_r1 = vecs[i].rf1; rf_r2 = vecs[i].rf2;
            ex_fwd_valid = vecs[i].exv; ex_is_load = vecs[i].exl; ex_rd = vecs[i].exrd; ex_data = vecs[i].exd;
            mem_fwd_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].md;
            wb_wen = vecs[i].wv; wb_rd = vecs[i].wrd; wb_data = vecs[i].wd;
            #1;
            chk($sformatf("vec%0d_ready", i), in_ready, vecs[i].e_rdy);
            tick();
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_rdy);
            if (vecs[i].e_rdy) begin
                chk($sformatf("vec%0d_op1", i), out_op1, vecs[i].e_op1);
                chk($sformatf("vec%0d_op2", i), out_op2, vecs[i].e_op2);
            end
        end
        clr_in();

        // Load-use stall resolved through the MEM bypass
        do_reset();
        in_valid = 1; in_rs1 = 1; in_rs2 = 7; in_use_rs1 = 0; in_use_rs2 = 1; rf_r2 = 32'h99;
        ex_fwd_valid = 1; ex_is_load = 1; ex_rd = 7; ex_data = 32'hDEAD;
        #1;
        chk("lu_ready", in_ready, 0);
        tick();
        chk("lu_stall1", stall_cnt, 1);
        chk("lu_novalid", out_valid, 0);
        ex_fwd_valid = 0; ex_is_load = 0; mem_fwd_valid = 1; mem_rd = 7; mem_data = 32'h55;
        #1;
        chk("lu_ready2", in_ready, 1);
        tick();
        chk("lu_valid", out_valid, 1);
        chk("lu_op2", out_op2, 32'h55);
        chk("lu_stall_hold", stall_cnt, 1);
        mem_fwd_valid = 0;
        ex_fwd_valid = 1; ex_is_load = 1; ex_rd = 7; in_use_rs2 = 0;
        #1;
        chk("nouse_ready", in_ready, 1);
        tick();
        chk("nouse_stall", stall_cnt, 1);
        clr_in();

        // Backpressure
        in_valid = 1; in_pc = 32'hA0;
        tick();
        chk("bp_loadA", out_pc, 32'hA0);
        out_ready = 0; in_pc = 32'hB0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", in_ready, 0);
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_hold", out_pc, 32'hA0);
        end
        out_ready = 1;
        #1;
        chk("bp_release", in_ready, 1);
        tick();
        chk("bp_pcB", out_pc, 32'hB0);
        in_pc = 32'hC0;
        tick();
        chk("bp_b2b_valid", out_valid, 1);
        chk("bp_pcC", out_pc, 32'hC0);

        // Flush with held and incoming instruction
        in_pc = 32'hD0; flush = 1;
        #1;
        chk("fl_ready", in_ready, 0);
        tick();
        chk("fl_valid", out_valid, 0);
        flush = 0; in_valid = 0;

        // Reset with an instruction held
        in_valid = 1; in_pc = 32'hE0; out_ready = 0;
        tick();
        chk("rh_valid", out_valid, 1);
        in_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("rh_drop", out_valid, 0);
        chk("rh_pc", out_pc, 0);
        chk("rh_stall", stall_cnt, 0);
        clr_in();

        // Stall counter saturation
        in_valid = 1; in_rs1 = 3; in_use_rs1 = 1; ex_fwd_valid = 1; ex_is_load = 1; ex_rd = 3;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        chk("sat_fffe", stall_cnt, 16'hFFFE);
        for (int i = 0; i < 6; i++) @(posedge clk);
        #1;
        chk("sat_ffff", stall_cnt, 16'hFFFF);
        clr_in();

        // Randomized traffic vs reference model
        do_reset();
        q.delete();
        exp_stall = 0;
        for (int c = 0; c < 400; c++) begin
            logic haz, busy, rdy;
            rec_t r;
            rst           = ($urandom_range(0, 49) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            in_valid      = $urandom_range(0, 3) != 0;
            out_ready     = $urandom_range(0, 3) != 0;
            in_rs1        = 5'($urandom_range(0, 3));
            in_rs2        = 5'($urandom_range(0, 3));
            in_rd         = 5'($urandom);
            in_use_rs1    = 1'($urandom);
            in_use_rs2    = 1'($urandom);
            in_imm        = $urandom; in_pc = $urandom; in_ctrl = 16'($urandom);
            rf_r1         = $urandom; rf_r2 = $urandom;
            ex_fwd_valid  = 1'($urandom); ex_is_load = ($urandom_range(0, 3) == 0);
            ex_rd         = 5'($urandom_range(0, 3)); ex_data = $urandom;
            mem_fwd_valid = 1'($urandom); mem_rd = 5'($urandom_range(0, 3)); mem_data = $urandom;
            wb_wen        = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
            #1;
            haz  = in_valid && ex_fwd_valid && ex_is_load && ex_rd != 0 &&
                   ((in_use_rs1 && in_rs1 == ex_rd) || (in_use_rs2 && in_rs2 == ex_rd));
            busy = (q.size() != 0) && !out_ready;
            rdy  = !busy && !haz && !flush;
            chk("rnd_ready", in_ready, rdy);
            chk("rnd_rfrs1", rf_rs1, in_rs1);
            chk("rnd_rfrs2", rf_rs2, in_rs2);
            r.op1 = ref_op(in_rs1, rf_r1); r.op2 = ref_op(in_rs2, rf_r2);
            r.imm = in_imm; r.pc = in_pc; r.rd = in_rd; r.ctrl = in_ctrl;
            tick();
            if (rst) begin
                q.delete();
                exp_stall = 0;
                chk("rnd_rst_op1", out_op1, 0);
                chk("rnd_rst_ctrl", out_ctrl, 0);
            end else begin
                if (q.size() != 0 && (out_ready || flush)) void'(q.pop_front());
                if (in_valid && rdy) q.push_back(r);
                if (haz && !flush && !busy && exp_stall < 65535) exp_stall++;
            end
            chk("rnd_valid", out_valid, q.size() != 0);
            chk("rnd_stall", stall_cnt, exp_stall);
            if (q.size() != 0) begin
                chk("rnd_op1", out_op1, q[0].op1);
                chk("rnd_op2", out_op2, q[0].op2);
                chk("rnd_imm", out_imm, q[0].imm);
                chk("rnd_pc", out_pc, q[0].pc);
                chk("rnd_rd", out_rd, q[0].rd);
                chk("rnd_ctrl", out_ctrl, q[0].ctrl);
            end
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-to-execute pipeline stage that drives the register file read addresses, collects the two source operands, and resolves data hazards. Operands are taken from bypass sources (EX, MEM, WB) in priority order, or from the register file when no source matches. A load-use hazard stalls the stage. The result is registered into the ID/EX pipeline register behind a valid/ready handshake.

## Interface
- XLEN, 32, operand/immediate/PC width
- CTRL_W, 16, width of opaque decoded-control bundle passed through
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1, in_rs2, in_rd  in  5  register indices
- in_use_rs1, in_use_rs2  in  1  instruction actually reads rs1/rs2
- in_imm, in_pc  in  XLEN  immediate, PC
- in_ctrl  in  CTRL_W  control bundle
- rf_rs1, rf_rs2  out  5  register-file read addresses (= in_rs1/in_rs2, combinational)
- rf_r1, rf_r2  in  XLEN  register-file read data (combinational read)
- ex_fwd_valid, ex_is_load  in  1  EX stage holds a reg-writing instr / it is a load
- ex_rd  in  5;  ex_data  in  XLEN
- mem_fwd_valid  in  1;  mem_rd  in  5;  mem_data  in  XLEN
- wb_wen  in  1;  wb_rd  in  5;  wb_data  in  XLEN  (same nets as the register-file write port)
- flush  in  1  squash: kill held and incoming instruction
- out_valid  out  1;  out_ready  in  1
- out_op1, out_op2, out_imm, out_pc  out  XLEN
- out_rd  out  5;  out_ctrl  out  CTRL_W
- stall_cnt  out  16  saturating count of load-use stall cycles

## Operation
- Operand select per source s (rs1, rs2), evaluated combinationally:
  - If idx == 0, select 0. No source matches x0.
  - Otherwise, the first match in this order: ex_fwd_valid && ex_rd==idx && !ex_is_load → ex_data; mem_fwd_valid && mem_rd==idx → mem_data; wb_wen && wb_rd==idx → wb_data; else rf_rN.
  - The WB bypass is mandatory: the register file writes at the edge, so a same-cycle read returns the stale value.
- Load-use hazard:
  - hazard = in_valid && ex_fwd_valid && ex_is_load && ex_rd!=0 && ((in_use_rs1 && in_rs1==ex_rd) || (in_use_rs2 && in_rs2==ex_rd)).
  - Unused sources never cause a hazard.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Accept = in_valid && in_ready. On accept, all out_* fields load and out_valid becomes 1 next cycle.
- If out_valid && out_ready && !accept, out_valid becomes 0. If !out_ready, all outputs hold unchanged. Registered data never changes while out_valid && !out_ready.
- flush: out_valid becomes 0 next cycle and nothing is accepted. Data registers may hold stale values.
- stall_cnt increments by 1 for each cycle with hazard && !flush && (!out_valid || out_ready), and saturates at 16'hFFFF. Only rst clears it.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction per cycle when there is no hazard and out_ready is high.
- Reset: rst takes priority over flush and accept. After the edge: out_valid=0, out_op1/op2/imm/pc=0, out_rd=0, out_ctrl=0, stall_cnt=0.
- Reset mid-operation drops any held instruction.
- The load-use hazard lasts exactly as long as the load sits in EX, normally 1 cycle. The instruction is accepted the following cycle with the value taken from the MEM bypass.
- Simultaneous out_ready and accept: the old output retires and the new one loads in the same edge, and out_valid stays 1.
- Simultaneous flush and out_ready: out_valid becomes 0.
- rf_rs1/rf_rs2 follow in_rs1/in_rs2 in every cycle, whether or not in_valid is asserted.

## Test plan
- Reset then idle → all outputs 0, in_ready=1. Then accept rs1=3, rs2=4 with rf_r1=0x11, rf_r2=0x22, no bypass → next cycle out_valid=1, out_op1=0x11, out_op2=0x22.
- Priority: rs1=5 with ex(rd5, 0xA), mem(rd5, 0xB), wb(rd5, 0xC), rf 0xD → op1=0xA. Remove ex → 0xB. Remove mem → 0xC. wb_rd=0 with rs1=0 → op1=0.
- Load-use: ex_is_load, ex_rd=7, in_rs2=7, in_use_rs2=1 → in_ready=0 for 1 cycle and stall_cnt=1. Next cycle, ex clear and mem(rd7, 0x55) → op2=0x55. Same case with in_use_rs2=0 → no stall.
- Backpressure: out_ready=0 for 3 cycles with in_valid held → outputs stable, in_ready=0. Release out_ready → back-to-back accepts, out_valid stays 1.
- flush with out_valid=1 and in_valid=1 → next cycle out_valid=0, nothing accepted. rst asserted while an instruction is held → out_valid=0, stall_cnt=0.
- Saturation: force 65540 stall cycles → stall_cnt=16'hFFFF.
